// File: rtl/effect_param_ctrl.sv
// effect_param_ctrl
//
// Parameter controller for the audio effect chain. Single-cycle user command
// pulses become per-effect enable bits and 3-bit levels. A captured command is
// applied only on a sample-boundary strobe (i_valid), so an effect never sees
// its parameters change while a sample is in flight. A short mute window is
// opened after every enable toggle to hide the click.
//
// Parameters:
//   N_EFFECTS      number of effects controlled (>= 2)
//   SEL_W          width of the selection index (2**SEL_W >= N_EFFECTS)
//   LOCKOUT_CYCLES clock cycles after an apply during which commands are ignored (>= 1)
//   MUTE_SAMPLES   sample strobes muted after an enable toggle (0 = no muting)
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_valid          sample-boundary strobe, one cycle wide
//   i_sel_next       pulse: advance the selected effect
//   i_toggle         pulse: invert the enable of the selected effect
//   i_level_up       pulse: increment the selected level (saturates at 7)
//   i_level_down     pulse: decrement the selected level (saturates at 0)
//   o_enable[k]      enable of effect k
//   o_level[3k+2:3k] level of effect k
//   o_sel            currently selected effect
//   o_busy           high whenever the controller is not idle
//   o_update         one-cycle pulse in the cycle new parameters first appear
//   o_mute           high while the post-toggle mute window is active

module effect_param_ctrl #(
  parameter int N_EFFECTS      = 4,
  parameter int SEL_W          = 2,
  parameter int LOCKOUT_CYCLES = 1024,
  parameter int MUTE_SAMPLES   = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic                   i_sel_next,
  input  logic                   i_toggle,
  input  logic                   i_level_up,
  input  logic                   i_level_down,
  output logic [N_EFFECTS-1:0]   o_enable,
  output logic [3*N_EFFECTS-1:0] o_level,
  output logic [SEL_W-1:0]       o_sel,
  output logic                   o_busy,
  output logic                   o_update,
  output logic                   o_mute
);

  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam int MUTE_W = (MUTE_SAMPLES > 0) ? $clog2(MUTE_SAMPLES + 1) : 1;

  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);
  localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);
  localparam logic [MUTE_W-1:0] MUTE_LOAD = MUTE_W'(MUTE_SAMPLES);
  localparam logic [MUTE_W-1:0] MUTE_ONE  = MUTE_W'(1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(N_EFFECTS - 1);
  localparam logic [SEL_W-1:0]  SEL_ONE   = SEL_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    LOCKOUT
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_TOGGLE,
    CMD_UP,
    CMD_DOWN,
    CMD_SEL
  } cmd_t;

  state_t                 state, next_state;
  cmd_t                   pend_cmd, next_cmd;
  logic [LOCK_W-1:0]      lock_cnt, next_lock_cnt;
  logic [MUTE_W-1:0]      mute_cnt, next_mute_cnt;
  logic                   apply;
  logic [N_EFFECTS-1:0]   next_enable;
  logic [3*N_EFFECTS-1:0] next_level;
  logic [SEL_W-1:0]       next_sel;

  // Control FSM: capture one command in IDLE, wait for a sample boundary in
  // PENDING, then hold off new commands for LOCKOUT_CYCLES clocks.
  always_comb begin
    next_state    = state;
    next_cmd      = pend_cmd;
    next_lock_cnt = lock_cnt;
    apply         = 1'b0;

    case (state)
      IDLE: begin
        // Simultaneous pulses resolve to one command; the rest are dropped.
        if (i_toggle)          next_cmd = CMD_TOGGLE;
        else if (i_level_up)   next_cmd = CMD_UP;
        else if (i_level_down) next_cmd = CMD_DOWN;
        else if (i_sel_next)   next_cmd = CMD_SEL;
        else                   next_cmd = CMD_NONE;

        if (i_toggle || i_level_up || i_level_down || i_sel_next)
          next_state = PENDING;
      end

      PENDING: begin
        if (i_valid) begin
          apply         = 1'b1;
          next_cmd      = CMD_NONE;
          next_lock_cnt = LOCK_LOAD;
          next_state    = LOCKOUT;
        end
      end

      LOCKOUT: begin
        if (lock_cnt != '0)
          next_lock_cnt = lock_cnt - LOCK_ONE;
        // Leaving on the last decrement puts us in IDLE the cycle after it.
        if (lock_cnt <= LOCK_ONE)
          next_state = IDLE;
      end

      default: begin
        next_state = IDLE;
        next_cmd   = CMD_NONE;
      end
    endcase
  end

  // Parameter update and mute window. The selection is read at apply time;
  // it cannot move while a command is pending because only one is in flight.
  always_comb begin
    next_enable   = o_enable;
    next_level    = o_level;
    next_sel      = o_sel;
    next_mute_cnt = mute_cnt;

    if (i_valid && (mute_cnt != '0))
      next_mute_cnt = mute_cnt - MUTE_ONE;

    if (apply) begin
      case (pend_cmd)
        CMD_SEL: begin
          next_sel = (o_sel == SEL_LAST) ? '0 : o_sel + SEL_ONE;
        end

        CMD_TOGGLE: begin
          for (int k = 0; k < N_EFFECTS; k++) begin
            if (o_sel == SEL_W'(k))
              next_enable[k] = ~o_enable[k];
          end
          // A load wins over the decrement issued by the same strobe.
          next_mute_cnt = MUTE_LOAD;
        end

        CMD_UP: begin
          for (int k = 0; k < N_EFFECTS; k++) begin
            if ((o_sel == SEL_W'(k)) && (o_level[3*k +: 3] != 3'd7))
              next_level[3*k +: 3] = o_level[3*k +: 3] + 3'd1;
          end
        end

        CMD_DOWN: begin
          for (int k = 0; k < N_EFFECTS; k++) begin
            if ((o_sel == SEL_W'(k)) && (o_level[3*k +: 3] != 3'd0))
              next_level[3*k +: 3] = o_level[3*k +: 3] - 3'd1;
          end
        end

        default: begin
        end
      endcase
    end
  end

  // State and parameter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      pend_cmd <= CMD_NONE;
      lock_cnt <= '0;
      mute_cnt <= '0;
      o_enable <= '0;
      o_level  <= '0;
      o_sel    <= '0;
      o_update <= 1'b0;
    end else begin
      state    <= next_state;
      pend_cmd <= next_cmd;
      lock_cnt <= next_lock_cnt;
      mute_cnt <= next_mute_cnt;
      o_enable <= next_enable;
      o_level  <= next_level;
      o_sel    <= next_sel;
      o_update <= apply;
    end
  end

  // Both flags decode registers only, so no input reaches an output directly.
  assign o_busy = (state != IDLE);
  assign o_mute = (mute_cnt != '0);

endmodule

// File: tb/tb_effect_param_ctrl.sv
// tb_effect_param_ctrl
//
// Self-checking bench for effect_param_ctrl (N_EFFECTS=4, LOCKOUT_CYCLES=8,
// MUTE_SAMPLES=4). A table of command vectors with their expected parameter
// state is driven through the controller; the expected state is queued when
// the applying strobe is driven and compared by a monitor when o_update fires.
// Hand-written sequences cover capture/strobe coincidence, lockout, the mute
// window and its reload, and reset in the middle of a pending command.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_effect_param_ctrl;

  localparam int N    = 4;
  localparam int SW   = 2;
  localparam int LOCK = 8;
  localparam int MUTE = 4;

  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic           i_valid = 1'b0;
  logic           i_sel_next = 1'b0;
  logic           i_toggle = 1'b0;
  logic           i_level_up = 1'b0;
  logic           i_level_down = 1'b0;
  logic [N-1:0]   o_enable;
  logic [3*N-1:0] o_level;
  logic [SW-1:0]  o_sel;
  logic           o_busy;
  logic           o_update;
  logic           o_mute;

  effect_param_ctrl #(
    .N_EFFECTS      (N),
    .SEL_W          (SW),
    .LOCKOUT_CYCLES (LOCK),
    .MUTE_SAMPLES   (MUTE)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_sel_next   (i_sel_next),
    .i_toggle     (i_toggle),
    .i_level_up   (i_level_up),
    .i_level_down (i_level_down),
    .o_enable     (o_enable),
    .o_level      (o_level),
    .o_sel        (o_sel),
    .o_busy       (o_busy),
    .o_update     (o_update),
    .o_mute       (o_mute)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic           tog;
    logic           up;
    logic           dn;
    logic           nxt;
    logic [SW-1:0]  e_sel;
    logic [N-1:0]   e_en;
    logic [3*N-1:0] e_lvl;
  } vec_t;

  typedef struct {
    logic [N-1:0]   en;
    logic [3*N-1:0] lvl;
    logic [SW-1:0]  sel;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic expectUpdate(input logic [N-1:0] en, input logic [3*N-1:0] lvl, input logic [SW-1:0] sel);
    exp_t e;
    e.en  = en;
    e.lvl = lvl;
    e.sel = sel;
    sb_q.push_back(e);
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (o_busy && n < 200) begin
      tick();
      n++;
    end
    checkOutput({name, "_idle_timeout"}, 32'(o_busy), 32'd0);
  endtask

  task automatic pulseValid();
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic addVec(input logic tog, input logic up, input logic dn, input logic nxt,
                        input logic [SW-1:0] s, input logic [N-1:0] en, input logic [3*N-1:0] lvl);
    vec_t v;
    v.tog   = tog;
    v.up    = up;
    v.dn    = dn;
    v.nxt   = nxt;
    v.e_sel = s;
    v.e_en  = en;
    v.e_lvl = lvl;
    vecs.push_back(v);
  endtask

  // Capture one command, let it sit pending without a strobe, then apply it.
  // Returns two cycles after the strobe, with the controller in lockout.
  task automatic applyStimulus(input vec_t v, input int idx);
    waitIdle($sformatf("vec%0d", idx));
    i_toggle     = v.tog;
    i_level_up   = v.up;
    i_level_down = v.dn;
    i_sel_next   = v.nxt;
    tick();
    i_toggle     = 1'b0;
    i_level_up   = 1'b0;
    i_level_down = 1'b0;
    i_sel_next   = 1'b0;
    checkOutput($sformatf("vec%0d_busy_after_capture", idx), 32'(o_busy), 32'd1);
    repeat (3) tick();
    checkOutput($sformatf("vec%0d_no_apply_without_valid", idx), 32'(o_update), 32'd0);
    expectUpdate(v.e_en, v.e_lvl, v.e_sel);
    pulseValid();
    checkOutput($sformatf("vec%0d_update_after_valid", idx), 32'(o_update), 32'd1);
    tick();
    checkOutput($sformatf("vec%0d_update_one_cycle", idx), 32'(o_update), 32'd0);
  endtask

  // Scoreboard monitor: every update must match the oldest queued expectation.
  always @(negedge i_clk) begin
    if (i_rst_n && o_update) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_update: got o_update=1, expected 0 with nothing pending");
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("sb_enable", 32'(o_enable), 32'(mon_e.en));
        checkOutput("sb_level", 32'(o_level), 32'(mon_e.lvl));
        checkOutput("sb_sel", 32'(o_sel), 32'(mon_e.sel));
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    vec_t v;

    // Reset held for 5 cycles, checked during and after.
    i_rst_n = 1'b0;
    repeat (5) tick();
    checkOutput("rst_enable", 32'(o_enable), 32'd0);
    checkOutput("rst_level", 32'(o_level), 32'd0);
    checkOutput("rst_sel", 32'(o_sel), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_update", 32'(o_update), 32'd0);
    checkOutput("rst_mute", 32'(o_mute), 32'd0);
    i_rst_n = 1'b1;
    tick();
    checkOutput("post_rst_enable", 32'(o_enable), 32'd0);
    checkOutput("post_rst_level", 32'(o_level), 32'd0);
    checkOutput("post_rst_sel", 32'(o_sel), 32'd0);
    checkOutput("post_rst_busy", 32'(o_busy), 32'd0);
    checkOutput("post_rst_mute", 32'(o_mute), 32'd0);

    //         tog   up    dn    nxt   sel    enable   levels
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 12'h001);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 12'h002);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 12'h003);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 12'h004);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 12'h005);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 12'h006);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 12'h007);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 12'h007);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 12'h007);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 12'h007);
    addVec(1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 12'h007);
    addVec(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 12'h006);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 12'h006);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 12'h006);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0000, 12'h006);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 12'h006);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 12'h007);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 12'h007);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 12'h00F);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0010, 12'h00F);
    addVec(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0010, 12'h007);
    addVec(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0010, 12'h007);

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], i);
    waitIdle("table_end");

    // Drain any mute window left over from the table toggles.
    n = 0;
    while (o_mute && n < 20) begin
      pulseValid();
      n++;
    end
    checkOutput("mute_drained", 32'(o_mute), 32'd0);

    // Command and strobe in the same idle cycle: captured, not applied.
    i_level_up = 1'b1;
    i_valid    = 1'b1;
    tick();
    i_level_up = 1'b0;
    i_valid    = 1'b0;
    checkOutput("same_cycle_no_update", 32'(o_update), 32'd0);
    checkOutput("same_cycle_busy", 32'(o_busy), 32'd1);
    repeat (2) tick();
    expectUpdate(4'b0010, 12'h00F, 2'd1);
    pulseValid();
    checkOutput("same_cycle_applied_next_valid", 32'(o_update), 32'd1);
    checkOutput("same_cycle_level", 32'(o_level), 32'h00F);

    // Lockout: a command and a strobe inside the window are ignored, and the
    // window lasts exactly LOCK cycles counted from the update cycle.
    v.tog = 1'b0; v.up = 1'b0; v.dn = 1'b0; v.nxt = 1'b1;
    v.e_sel = 2'd2; v.e_en = 4'b0010; v.e_lvl = 12'h00F;
    applyStimulus(v, 100);
    n = 2;
    for (int k = 0; k < 50 && o_busy; k++) begin
      i_level_up = (k == 0);
      i_valid    = (k == 2);
      tick();
      if (o_busy) n++;
    end
    i_level_up = 1'b0;
    i_valid    = 1'b0;
    checkOutput("lockout_length", 32'(n), 32'(LOCK));
    tick();
    checkOutput("lockout_cmd_not_pending", 32'(o_busy), 32'd0);
    pulseValid();
    checkOutput("lockout_cmd_not_applied", 32'(o_update), 32'd0);
    checkOutput("lockout_level_kept", 32'(o_level), 32'h00F);

    // Toggle opens a mute window of exactly MUTE strobes.
    v.tog = 1'b1; v.up = 1'b0; v.dn = 1'b0; v.nxt = 1'b0;
    v.e_sel = 2'd2; v.e_en = 4'b0110; v.e_lvl = 12'h00F;
    applyStimulus(v, 200);
    checkOutput("mute_rise", 32'(o_mute), 32'd1);
    for (int i = 1; i <= MUTE; i++) begin
      pulseValid();
      checkOutput($sformatf("mute_after_valid%0d", i), 32'(o_mute), 32'(i < MUTE));
    end

    // A toggle inside the window reloads the count to MUTE.
    v.e_en = 4'b0010;
    applyStimulus(v, 201);
    checkOutput("mute_reload_first_rise", 32'(o_mute), 32'd1);
    repeat (2) pulseValid();
    checkOutput("mute_mid_window", 32'(o_mute), 32'd1);
    v.e_en = 4'b0110;
    applyStimulus(v, 202);
    for (int i = 1; i <= MUTE; i++) begin
      pulseValid();
      checkOutput($sformatf("mute_reload_valid%0d", i), 32'(o_mute), 32'(i < MUTE));
    end

    // Reset while a command is pending and a mute window is open.
    v.e_en = 4'b0010;
    applyStimulus(v, 203);
    waitIdle("pre_reset");
    i_level_up = 1'b1;
    tick();
    i_level_up = 1'b0;
    checkOutput("pending_before_reset", 32'(o_busy), 32'd1);
    checkOutput("mute_before_reset", 32'(o_mute), 32'd1);
    i_rst_n = 1'b0;
    #1;
    checkOutput("midop_rst_enable", 32'(o_enable), 32'd0);
    checkOutput("midop_rst_level", 32'(o_level), 32'd0);
    checkOutput("midop_rst_sel", 32'(o_sel), 32'd0);
    checkOutput("midop_rst_busy", 32'(o_busy), 32'd0);
    checkOutput("midop_rst_mute", 32'(o_mute), 32'd0);
    repeat (2) tick();
    i_rst_n = 1'b1;
    tick();
    pulseValid();
    checkOutput("midop_no_apply", 32'(o_update), 32'd0);
    checkOutput("midop_level_after", 32'(o_level), 32'd0);
    checkOutput("midop_busy_after", 32'(o_busy), 32'd0);
    checkOutput("midop_enable_after", 32'(o_enable), 32'd0);

    tick();
    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/effect_param_ctrl.md
# effect_param_ctrl

Parameter controller for the audio effect chain (gate, and further effects with the same `i_enable`/`i_level[2:0]` interface). It turns single-cycle user command pulses into per-effect enable bits and 3-bit levels. Every change is applied only at a sample boundary, marked by the `i_valid` strobe, so no effect sees its parameters change while a sample is in flight. It sits between the button/switch front end (already debounced and edge-detected to pulses) and the effect modules. It also issues a short output-mute window after any enable toggle to suppress clicks.

## Interface
- `N_EFFECTS`, default 4: number of effects controlled; must be ≥ 2.
- `SEL_W`, default 2: width of the selection index; must satisfy 2^SEL_W ≥ N_EFFECTS.
- `LOCKOUT_CYCLES`, default 1024: number of clock cycles after an apply during which new commands are ignored; must be ≥ 1.
- `MUTE_SAMPLES`, default 64: number of sample strobes muted after an enable toggle; 0 disables muting.

Ports:
- `i_clk` in, 1: the single clock.
- `i_rst_n` in, 1: asynchronous, active-low reset.
- `i_valid` in, 1: sample-boundary strobe, one cycle wide (the same strobe that feeds the first effect).
- `i_sel_next` in, 1: pulse; advance the selected effect.
- `i_toggle` in, 1: pulse; invert the enable of the selected effect.
- `i_level_up` in, 1: pulse; increment the level of the selected effect.
- `i_level_down` in, 1: pulse; decrement the level of the selected effect.
- `o_enable` out, N_EFFECTS: bit k is the `i_enable` of effect k.
- `o_level` out, 3*N_EFFECTS: bits [3k+2:3k] are the `i_level` of effect k.
- `o_sel` out, SEL_W: index of the currently selected effect.
- `o_busy` out, 1: high when the FSM is not in IDLE.
- `o_update` out, 1: one-cycle pulse marking the cycle in which the new parameters first appear on the outputs.
- `o_mute` out, 1: high while the post-toggle mute window is active; downstream forces its sample output to 0 while this is high.

## Operation
- FSM states: IDLE, PENDING, LOCKOUT.
- **IDLE**
  - Any command pulse is captured into a pending-command register, and the state moves to PENDING.
  - If several command pulses arrive in the same cycle, exactly one is captured, by priority: toggle > level_up > level_down > sel_next. The others are dropped.
- **PENDING**
  - All command inputs are ignored.
  - On `i_valid`, the pending command is applied, `o_update` pulses, the lockout counter is loaded with LOCKOUT_CYCLES, and the state moves to LOCKOUT.
- **LOCKOUT**
  - All command inputs are ignored.
  - The lockout counter decrements every cycle.
  - When the counter reaches 0, the state returns to IDLE. It is in IDLE at the cycle after the counter's last decrement.
- Apply rules:
  - sel_next: `o_sel` becomes `o_sel`+1, wrapping from N_EFFECTS-1 to 0.
  - toggle: `o_enable[o_sel]` is inverted, and the mute counter is loaded with MUTE_SAMPLES. A toggle during an active mute window reloads the counter.
  - level_up: the selected level increments and saturates at 7.
  - level_down: the selected level decrements and saturates at 0.
  - A saturated level change still completes the apply: `o_update` pulses and LOCKOUT is entered.
- The selected index is read at apply time, not at capture time. It cannot change in between, because only one command is in flight at a time.
- Mute counter:
  - `o_mute` is high while the counter is nonzero.
  - The counter decrements on each `i_valid`.
  - A load takes precedence over a decrement in the same cycle.
- Reset values: `o_enable`=0, all levels=0, `o_sel`=0, `o_busy`=0, `o_update`=0, `o_mute`=0, state IDLE, all counters 0.
- An asserted `i_rst_n` in any state, including mid-PENDING or mid-mute, discards the pending command and returns every output to its reset value immediately.

## Timing
- A command captured at cycle t sets `o_busy`=1 at t+1.
- `i_valid` at cycle u while in PENDING puts the new parameter values, and `o_update`=1, on the outputs at u+1.
  - Effects clocking a sample on `i_valid` at u therefore use the old parameters.
  - The next sample uses the new parameters.
- A command pulse and `i_valid` in the same IDLE cycle: the command is captured, and it is not applied on that strobe. It applies on the next `i_valid`.
- `o_mute` rises at u+1 together with the toggled enable. It stays high for exactly MUTE_SAMPLES subsequent `i_valid` strobes, then falls in the cycle after the last of them.
- `i_valid` is never required to arrive. PENDING waits indefinitely, with `o_busy` held high.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- **Reset:** hold `i_rst_n`=0 for 5 cycles, then release → `o_enable`=0, all levels 0, `o_sel`=0, `o_busy`=0, `o_mute`=0.
- **Level up and saturation:** issue 9 `i_level_up` pulses, each after `o_busy` falls, with `i_valid` every 100 cycles → level0 goes 1,2,…,7,7,7; `o_update` pulses 9 times; each update lands the cycle after an `i_valid`.
- **Toggle and mute (MUTE_SAMPLES=4):** one `i_toggle` pulse → `o_enable[0]`=1 at u+1; `o_mute` high for exactly 4 `i_valid` strobes.
  - A second toggle applied during the mute window reloads the count to 4.
- **Simultaneous commands:** `i_toggle`, `i_level_up` and `i_sel_next` in the same cycle → only the toggle is applied; `o_sel` stays 0 and the level is unchanged.
- **Selection wrap (N_EFFECTS=4):** 4 `i_sel_next` applies → `o_sel` goes 1,2,3,0. A level_up after the wrap changes only bits [2:0] of `o_level`.
- **Lockout and reset mid-op:** a pulse during LOCKOUT is ignored (no `o_update`).
  - Assert `i_rst_n`=0 while in PENDING → no apply on the next `i_valid`; all outputs are at their reset values.
